// File: rtl/km_sub_seq.sv
// Sequential Karatsuba / dual-product multiplier built around one shared
// pipelined (WIDTH+1)x(WIDTH+1) multiplier, with a valid/ready handshake on both sides.
module km_sub_seq #(
   parameter int WIDTH      = 16,
   parameter int MUL_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [2*WIDTH-1:0] a,
   input  logic [2*WIDTH-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic               out_mode
);

   localparam int HW = WIDTH + 1;
   localparam int PW = 2 * WIDTH + 2;
   localparam int RW = 4 * WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Tag travelling alongside each product: idx 0 = z0, 1 = z2, 2 = zs.
   typedef struct packed {
      logic       vld;
      logic [1:0] idx;
   } tag_t;

   logic [1:0]         state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic               mode_q, mode_d;
   tag_t               tag_q [MUL_STAGES];
   tag_t               tag_d [MUL_STAGES];
   logic [PW-1:0]      p_q   [MUL_STAGES];
   logic [PW-1:0]      p_d   [MUL_STAGES];
   logic [PW-1:0]      z0_q, z0_d, z2_q, z2_d;
   logic               out_valid_q, out_valid_d;
   logic [RW-1:0]      out_data_q, out_data_d;
   logic               out_mode_q, out_mode_d;

   logic               accept;
   logic               issuing;
   logic [1:0]         last_idx;
   logic [HW-1:0]      a_sum, b_sum;
   logic [HW-1:0]      mul_a, mul_b;
   tag_t               tag_in;
   logic               last_next;
   logic [PW-1:0]      p_out;
   tag_t               tag_out;
   logic [PW-1:0]      z1;
   logic [RW-1:0]      res_kara, res_dual;

   assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign issuing   = (state_q == S_ISSUE);
   assign last_idx  = mode_q ? 2'd2 : 2'd1;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;

   // Half sums carry one extra bit, so they cannot overflow.
   assign a_sum = {1'b0, a_q[WIDTH-1:0]} + {1'b0, a_q[2*WIDTH-1:WIDTH]};
   assign b_sum = {1'b0, b_q[WIDTH-1:0]} + {1'b0, b_q[2*WIDTH-1:WIDTH]};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      mul_a = '0;
      mul_b = '0;
      if (issuing) begin
         case (cnt_q)
            2'd0: begin
               mul_a = {1'b0, a_q[WIDTH-1:0]};
               mul_b = {1'b0, b_q[WIDTH-1:0]};
            end
            2'd1: begin
               mul_a = {1'b0, a_q[2*WIDTH-1:WIDTH]};
               mul_b = {1'b0, b_q[2*WIDTH-1:WIDTH]};
            end
            default: begin
               mul_a = a_sum;
               mul_b = b_sum;
            end
         endcase
      end
      tag_in.vld = issuing;
      tag_in.idx = issuing ? cnt_q : 2'd0;
   end

   always_comb begin
      p_d[0]   = {{HW{1'b0}}, mul_a} * {{HW{1'b0}}, mul_b};
      tag_d[0] = tag_in;
      for (int s = 1; s < MUL_STAGES; s++) begin
         p_d[s]   = p_q[s-1];
         tag_d[s] = tag_q[s-1];
      end
   end

   assign p_out     = p_q[MUL_STAGES-1];
   assign tag_out   = tag_q[MUL_STAGES-1];
   assign last_next = tag_d[MUL_STAGES-1].vld && (tag_d[MUL_STAGES-1].idx == last_idx);

   always_comb begin
      z0_d = z0_q;
      z2_d = z2_q;
      if (tag_out.vld && tag_out.idx == 2'd0) z0_d = p_out;
      if (tag_out.vld && tag_out.idx == 2'd1) z2_d = p_out;
   end

   // In DONE the last product sits at the multiplier output.
   assign z1       = p_out - z0_q - z2_q;
   assign res_kara = (RW'(z2_q) << (2 * WIDTH)) + (RW'(z1) << WIDTH) + RW'(z0_q);
   assign res_dual = {p_out[2*WIDTH-1:0], z0_q[2*WIDTH-1:0]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_mode_d  = out_mode_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ISSUE;
               cnt_d   = 2'd0;
               a_d     = a;
               b_d     = b;
               mode_d  = mode;
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + 2'd1;
            if (last_next)                state_d = S_DONE;
            else if (cnt_q == last_idx)   state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (last_next) state_d = S_DONE;
         end
         S_DONE: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b1;
            out_mode_d  = mode_q;
            out_data_d  = mode_q ? res_kara : res_dual;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= 1'b0;
         z0_q        <= '0;
         z2_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= 1'b0;
         for (int s = 0; s < MUL_STAGES; s++) begin
            tag_q[s] <= '0;
            p_q[s]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         mode_q      <= mode_d;
         z0_q        <= z0_d;
         z2_q        <= z2_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
         for (int s = 0; s < MUL_STAGES; s++) begin
            tag_q[s] <= tag_d[s];
            p_q[s]   <= p_d[s];
         end
      end
   end

endmodule

// File: tb/tb_km_sub_seq.sv
// Scoreboard bench for km_sub_seq: directed corner cases plus a random stream
// checked against plain integer multiplication.
module tb_km_sub_seq;

   localparam int W  = 16;
   localparam int MS = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          mode = 1'b0;
   logic [31:0]   a = '0;
   logic [31:0]   b = '0;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_data;
   logic          out_mode;

   logic          rdy_rand  = 1'b0;
   logic          rdy_fixed = 1'b1;
   logic          rnd_rdy   = 1'b1;
   assign out_ready = rdy_rand ? rnd_rdy : rdy_fixed;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [63:0] data;
      logic        m;
      int          acc;
   } exp_t;
   exp_t sb[$];

   km_sub_seq #(.WIDTH(W), .MUL_STAGES(MS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_mode(out_mode)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: full product, or the two independent half products side by side.
   function automatic logic [63:0] ref_model(input logic m, input logic [31:0] aa, input logic [31:0] bb);
      logic [63:0] full;
      logic [31:0] hi, lo;
      full = {32'b0, aa} * {32'b0, bb};
      hi   = {16'b0, aa[31:16]} * {16'b0, bb[31:16]};
      lo   = {16'b0, aa[15:0]} * {16'b0, bb[15:0]};
      return m ? full : {hi, lo};
   endfunction

   // Monitor: checks new results, hold stability, drop after consume, and records accepts.
   logic        prev_v = 1'b0, prev_r = 1'b0, prev_m = 1'b0;
   logic [63:0] prev_d = '0;
   always @(negedge clk) begin
      if (rst) begin
         check("in_ready_in_reset", in_ready, 0);
         sb.delete();
         prev_v = 1'b0;
         prev_r = 1'b0;
      end else begin
         if (prev_v && prev_r) check("valid_falls_after_consume", out_valid, 0);
         if (out_valid && !(prev_v && !prev_r)) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_mode", out_mode, e.m);
               check("latency", cyc - e.acc, (e.m ? 3 : 2) + MS);
            end
         end else if (out_valid) begin
            check("hold_data", out_data, prev_d);
            check("hold_mode", out_mode, prev_m);
         end
         if (out_valid && !out_ready) check("no_accept_while_blocked", in_ready, 0);
         if (in_valid && in_ready) begin
            exp_t e;
            e.data = ref_model(mode, a, b);
            e.m    = mode;
            e.acc  = cyc + 1;
            sb.push_back(e);
         end
         prev_v = out_valid;
         prev_r = out_ready;
         prev_d = out_data;
         prev_m = out_mode;
      end
   end

   task automatic send(input logic m, input logic [31:0] aa, input logic [31:0] bb);
      bit done = 1'b0;
      in_valid = 1'b1;
      mode     = m;
      a        = aa;
      b        = bb;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("accepted", done, 1);
   endtask

   task automatic wait_valid();
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("out_valid_seen", seen, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_mode", out_mode, 0);
      check("ready_after_reset", in_ready, 1);
      @(posedge clk);
      #1;

      // Dual product and Karatsuba with all-ones operands.
      send(1'b0, 32'h0003_0002, 32'h0005_0007);
      wait_valid();
      check("dual_directed", out_data, 64'h0000000F_0000000E);
      @(posedge clk);
      #1;
      send(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid();
      check("kara_all_ones", out_data, 64'hFFFFFFFE_00000001);
      check("kara_all_ones_mode", out_mode, 1);
      @(posedge clk);
      #1;

      // Back-pressure: result held, new op waiting, then accept with consume.
      rdy_fixed = 1'b0;
      send(1'b0, 32'hFFFF_FFFF, 32'h8001_FFFF);
      wait_valid();
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      mode     = 1'b1;
      a        = 32'h1234_5678;
      b        = 32'h9ABC_DEF0;
      repeat (3) begin
         @(negedge clk);
         check("blocked_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      rdy_fixed = 1'b1;
      @(negedge clk);
      check("accept_with_consume", {in_ready, out_valid}, 64'h3);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid();
      @(posedge clk);
      #1;

      // Reset two cycles after a mode-1 accept discards that operation.
      send(1'b1, 32'hABCD_1234, 32'h5678_EF01);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midop_reset_valid", out_valid, 0);
      check("midop_reset_data", out_data, 0);
      check("midop_reset_mode", out_mode, 0);
      check("midop_reset_ready", in_ready, 1);
      repeat (8) begin
         @(negedge clk);
         check("no_ghost_result", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(1'b1, 32'h0001_0000, 32'h0001_0000);
      wait_valid();
      check("after_reset_op", out_data, 64'h00000001_00000000);
      @(posedge clk);
      #1;

      // Random stream with random gaps and random back-pressure.
      rdy_rand = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         logic [31:0] ra, rb;
         int          g;
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         case ($urandom_range(0, 7))
            0:       begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
            1:       begin ra = 32'h0;         rb = $urandom;      end
            2:       begin ra = 32'hFFFF_0000; rb = 32'h0000_FFFF; end
            default: begin ra = $urandom;      rb = $urandom;      end
         endcase
         send(1'($urandom_range(0, 1)), ra, rb);
      end
      rdy_rand = 1'b0;
      for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) begin
         @(posedge clk);
         #1;
      end
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/km_sub_seq.md
KM_SUB_SEQ -- requirements
Module: km_sub_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: half-operand width in bits, legal range 4 to 64.
REQ-002 The block SHALL take parameter MUL_STAGES, default 2: register stages inside the shared multiplier, legal range 1 to 4.
REQ-003 Port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the operation on a/b/mode is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 Port mode, input, 1 bit: 0 selects dual product, 1 selects Karatsuba full product.
REQ-008 Port a, input, 2*WIDTH bits: operand A = {a1, a0}, each half WIDTH bits.
REQ-009 Port b, input, 2*WIDTH bits: operand B = {b1, b0}, each half WIDTH bits.
REQ-010 Port out_valid, output, 1 bit: out_data and out_mode hold a result.
REQ-011 Port out_ready, input, 1 bit: the downstream consumes the result.
REQ-012 Port out_data, output, 4*WIDTH bits: the result.
REQ-013 Port out_mode, output, 1 bit: the mode captured for the current result.

Function
REQ-014 The block SHALL use exactly one (WIDTH+1)x(WIDTH+1) unsigned multiplier, pipelined MUL_STAGES deep, time-shared across all partial products.
REQ-015 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; a, b and mode SHALL be captured only on that edge.
REQ-016 in_ready SHALL be 1 only when the FSM is in IDLE and (out_valid=0 or out_ready=1).
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-018 FSM transition: IDLE goes to ISSUE on accept.
REQ-019 FSM transition: ISSUE goes to DRAIN after the last partial product is issued.
REQ-020 FSM transition: DRAIN goes to DONE when the last product exits the pipeline.
REQ-021 FSM transition: DONE goes to IDLE in the same cycle the result register is loaded.
REQ-022 Issue order: z0=a0*b0, then z2=a1*b1, then (mode=1 only) zs=(a0+a1)*(b0+b1); one issue per cycle, no bubbles.
REQ-023 NPROD SHALL be 2 in mode 0 and 3 in mode 1.
REQ-024 out_valid SHALL rise exactly NPROD+MUL_STAGES cycles after the accept edge: 4 for mode 0 and 5 for mode 1 at MUL_STAGES=2.
REQ-025 Mode 0 result: out_data = {z2, z0}, each 2*WIDTH bits.
REQ-026 Mode 1 middle term: z1 = zs - z0 - z2, held as a 2*WIDTH+2 bit intermediate; it is never negative.
REQ-027 Mode 1 result: out_data = (z2 << 2*WIDTH) + (z1 << WIDTH) + z0, truncated to 4*WIDTH bits, which equals the exact A*B.
REQ-028 Sums a0+a1 and b0+b1 SHALL be WIDTH+1 bits and SHALL never overflow.
REQ-029 While out_valid=1 and out_ready=0, out_data, out_mode and out_valid SHALL hold stable and no new operation SHALL be accepted.
REQ-030 When the result is consumed (out_valid=1 and out_ready=1) with no new result loading, out_valid SHALL fall on the next edge.
REQ-031 When the result is consumed and in_valid=1 in IDLE in the same cycle, accept and consume SHALL both take effect on that edge.
REQ-032 Operands of all-ones in both halves SHALL produce correct results; there is no saturation and no wrap beyond 4*WIDTH bits.
REQ-033 The multiplier input SHALL be held at zero when nothing is issued; idle cycles SHALL NOT alter the captured operands.

Reset
REQ-034 When rst=1 at a rising edge, the FSM SHALL go to IDLE and out_valid SHALL go to 0.
REQ-035 When rst=1 at a rising edge, out_data SHALL go to 0 and out_mode SHALL go to 0.
REQ-036 When rst=1 at a rising edge, all pipeline valid tags and partial-product registers SHALL clear.
REQ-037 in_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after rst falls.
REQ-038 Reset asserted mid-operation SHALL discard the in-flight operation; no out_valid pulse SHALL appear for it.

Verification
REQ-039 WIDTH=16, MUL_STAGES=2, mode=0, a=0x0003_0002, b=0x0005_0007 -> out_data=0x0000000F_0000000E, out_valid 4 cycles after accept.
REQ-040 mode=1, a=0xFFFF_FFFF, b=0xFFFF_FFFF -> out_data=0xFFFFFFFE_00000001, out_valid 5 cycles after accept, out_mode=1.
REQ-041 Result pending with out_ready=0 for 3 cycles and in_valid=1 -> out_data stable, in_ready=0 throughout; raising out_ready -> accept occurs on the same edge as consume.
REQ-042 rst pulsed 2 cycles after a mode-1 accept -> no out_valid for that operation; the next operation, a=0x0001_0000 with b=0x0001_0000, gives out_data=0x00000001_00000000.
REQ-043 A stream of 1000 random operations with random mode and random in_valid/out_ready -> every out_data matches the reference A*B or {a1*b1, a0*b0}, in order, with no loss or duplication.
